// File: rtl/siphash_msg_feeder_if.sv
// Byte-stream, core command and result signals between siphash_msg_feeder and its neighbours.
// The slave modport is the feeder; master is the side driving the stream and emulating the core.
interface siphash_msg_feeder_if;
  logic        start;
  logic        start_empty;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        core_initalize;
  logic        core_compress;
  logic        core_finalize;
  logic [63:0] core_mi;
  logic        core_ready;
  logic        core_word_valid;
  logic [63:0] core_word;
  logic [63:0] hash;
  logic        hash_valid;
  logic        busy;

  modport slave (
    input  start, start_empty, in_valid, in_data, in_last,
           core_ready, core_word_valid, core_word,
    output in_ready, core_initalize, core_compress, core_finalize,
           core_mi, hash, hash_valid, busy
  );

  modport master (
    output start, start_empty, in_valid, in_data, in_last,
           core_ready, core_word_valid, core_word,
    input  in_ready, core_initalize, core_compress, core_finalize,
           core_mi, hash, hash_valid, busy
  );
endinterface

// File: rtl/siphash_msg_feeder.sv
// Packs a byte stream into little-endian 64-bit SipHash message words, appends the
// length byte, and sequences initialize/compress/finalize commands to an external core.
//
// state   | meaning
// IDLE    | waiting for start; hash/hash_valid held
// INIT    | waiting for core_ready, then pulse core_initalize
// COLLECT | accepting bytes into word_reg
// COMP    | waiting for core_ready, then pulse core_compress
// CWAIT   | waiting for the core to finish the compress
// FINAL   | pulse core_finalize
// FWAIT   | waiting for core_word_valid, then latch hash
module siphash_msg_feeder (
  input  logic                  clk,
  input  logic                  reset_n,
  siphash_msg_feeder_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, INIT, COLLECT, COMP, CWAIT, FINAL, FWAIT} state_t;

  state_t      state;
  logic [7:0]  len_reg;
  logic [2:0]  byte_cnt;
  logic [63:0] word_reg;
  logic        last_blk;
  logic        len_pending;
  logic        empty_reg;
  logic        init_q;
  logic        comp_q;
  logic        fin_q;
  logic [63:0] hash_q;
  logic        hash_valid_q;

  logic        accept;
  logic [7:0]  len_next;
  logic [63:0] word_next;

  assign accept   = (state == COLLECT) && bus.in_valid;
  assign len_next = len_reg + 8'd1;

  always_comb begin
    word_next = word_reg;
    word_next[{byte_cnt, 3'b000} +: 8] = bus.in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      len_reg      <= '0;
      byte_cnt     <= '0;
      word_reg     <= '0;
      last_blk     <= 1'b0;
      len_pending  <= 1'b0;
      empty_reg    <= 1'b0;
      init_q       <= 1'b0;
      comp_q       <= 1'b0;
      fin_q        <= 1'b0;
      hash_q       <= '0;
      hash_valid_q <= 1'b0;
    end else begin
      init_q <= 1'b0;
      comp_q <= 1'b0;
      fin_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= INIT;
            empty_reg    <= bus.start_empty;
            hash_valid_q <= 1'b0;
            len_reg      <= '0;
            byte_cnt     <= '0;
            word_reg     <= '0;
            last_blk     <= 1'b0;
            len_pending  <= 1'b0;
          end
        end
        INIT: begin
          if (bus.core_ready) begin
            init_q <= 1'b1;
            if (empty_reg) begin
              word_reg <= '0;
              last_blk <= 1'b1;
              state    <= COMP;
            end else begin
              state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 3'd1;
            len_reg  <= len_next;
            // Lanes above the final byte are already zero; only the length lane is filled.
            if (bus.in_last && byte_cnt != 3'd7) begin
              word_reg <= {len_next, word_next[55:0]};
              last_blk <= 1'b1;
              state    <= COMP;
            end else begin
              word_reg <= word_next;
              if (byte_cnt == 3'd7) begin
                len_pending <= bus.in_last;
                state       <= COMP;
              end
            end
          end
        end
        COMP: begin
          // core_ready is stale in the cycle the initialize pulse is still on the wire.
          if (bus.core_ready && !init_q) begin
            comp_q <= 1'b1;
            state  <= CWAIT;
          end
        end
        CWAIT: begin
          if (!comp_q && bus.core_ready) begin
            if (last_blk) begin
              state <= FINAL;
            end else if (len_pending) begin
              word_reg    <= {len_reg, 56'h0};
              len_pending <= 1'b0;
              last_blk    <= 1'b1;
              state       <= COMP;
            end else begin
              word_reg <= '0;
              state    <= COLLECT;
            end
          end
        end
        FINAL: begin
          fin_q <= 1'b1;
          state <= FWAIT;
        end
        FWAIT: begin
          if (!fin_q && bus.core_word_valid && bus.core_ready) begin
            hash_q       <= bus.core_word;
            hash_valid_q <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready       = (state == COLLECT);
  assign bus.busy           = (state != IDLE);
  assign bus.core_initalize = init_q;
  assign bus.core_compress  = comp_q;
  assign bus.core_finalize  = fin_q;
  assign bus.core_mi        = word_reg;
  assign bus.hash           = hash_q;
  assign bus.hash_valid     = hash_valid_q;

endmodule

// File: tb/tb_siphash_msg_feeder.sv
// Bench for siphash_msg_feeder: a SipHash-2-4 core emulator (key 00..0f) answers the
// feeder's commands; results are compared with a byte-level SipHash reference.
module tb_siphash_msg_feeder;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [63:0] word_q_t[$];

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  siphash_msg_feeder_if bus();
  siphash_msg_feeder dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  int total = 0;
  int bad   = 0;
  int extra = 0;
  int pulse_err = 0;
  logic [63:0]  mi_log[$];
  logic [255:0] cstate;
  int           cnt;
  logic         prev_ready;
  logic         fin_pending;

  function automatic logic [63:0] rotl(input logic [63:0] x, input int b);
    return (x << b) | (x >> (64 - b));
  endfunction

  function automatic logic [255:0] sip_round(input logic [255:0] s);
    logic [63:0] v0, v1, v2, v3;
    {v3, v2, v1, v0} = s;
    v0 = v0 + v1; v1 = rotl(v1, 13); v1 = v1 ^ v0; v0 = rotl(v0, 32);
    v2 = v2 + v3; v3 = rotl(v3, 16); v3 = v3 ^ v2;
    v0 = v0 + v3; v3 = rotl(v3, 21); v3 = v3 ^ v0;
    v2 = v2 + v1; v1 = rotl(v1, 17); v1 = v1 ^ v2; v2 = rotl(v2, 32);
    return {v3, v2, v1, v0};
  endfunction

  function automatic logic [255:0] sip_init();
    logic [63:0] k0, k1;
    k0 = 64'h0706050403020100;
    k1 = 64'h0f0e0d0c0b0a0908;
    return {k1 ^ 64'h7465646279746573, k0 ^ 64'h6c7967656e657261,
            k1 ^ 64'h646f72616e646f6d, k0 ^ 64'h736f6d6570736575};
  endfunction

  function automatic logic [255:0] sip_comp(input logic [255:0] s, input logic [63:0] m);
    logic [255:0] t;
    t = s;
    t[255:192] = t[255:192] ^ m;
    t = sip_round(sip_round(t));
    t[63:0] = t[63:0] ^ m;
    return t;
  endfunction

  function automatic logic [63:0] sip_fin(input logic [255:0] s);
    logic [255:0] t;
    t = s;
    t[191:128] = t[191:128] ^ 64'hff;
    for (int r = 0; r < 4; r++) t = sip_round(t);
    return t[63:0] ^ t[127:64] ^ t[191:128] ^ t[255:192];
  endfunction

  // SipHash message schedule: full 8-byte blocks, then the tail with length mod 256 on top.
  task automatic ref_words(input byte_q_t b, output word_q_t w);
    logic [63:0] m;
    int n;
    n = b.size();
    w.delete();
    for (int k = 0; k + 8 <= n; k += 8) begin
      m = '0;
      for (int j = 0; j < 8; j++) m[8*j +: 8] = b[k+j];
      w.push_back(m);
    end
    m = '0;
    for (int j = 0; j < n % 8; j++) m[8*j +: 8] = b[n - n % 8 + j];
    m[63:56] = 8'(n);
    w.push_back(m);
  endtask

  function automatic logic [63:0] ref_hash(input word_q_t w);
    logic [255:0] s;
    s = sip_init();
    foreach (w[k]) s = sip_comp(s, w[k]);
    return sip_fin(s);
  endfunction

  // Core emulator: drops ready for 2+extra cycles after each command.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.core_ready      <= 1'b1;
      bus.core_word_valid <= 1'b0;
      bus.core_word       <= '0;
      cnt                 <= 0;
      prev_ready          <= 1'b1;
      fin_pending         <= 1'b0;
    end else begin
      prev_ready <= bus.core_ready;
      if (int'(bus.core_initalize) + int'(bus.core_compress) + int'(bus.core_finalize) > 1)
        pulse_err <= pulse_err + 1;
      if ((bus.core_initalize || bus.core_compress) && !prev_ready)
        pulse_err <= pulse_err + 1;
      if (bus.core_initalize) begin
        cstate <= sip_init();
        bus.core_ready <= 1'b0; bus.core_word_valid <= 1'b0; cnt <= 1 + extra;
      end else if (bus.core_compress) begin
        cstate <= sip_comp(cstate, bus.core_mi);
        mi_log.push_back(bus.core_mi);
        bus.core_ready <= 1'b0; cnt <= 1 + extra;
      end else if (bus.core_finalize) begin
        bus.core_word <= sip_fin(cstate);
        bus.core_ready <= 1'b0; cnt <= 1 + extra; fin_pending <= 1'b1;
      end else if (!bus.core_ready) begin
        if (cnt == 0) begin
          bus.core_ready <= 1'b1;
          if (fin_pending) begin
            bus.core_word_valid <= 1'b1;
            fin_pending <= 1'b0;
          end
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.start = 1'b0; bus.start_empty = 1'b0; bus.in_valid = 1'b0;
    bus.in_data = '0; bus.in_last = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (bus.busy !== 1'b0 && c < 5000) begin @(negedge clk); c++; end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_wait busy=%b want=0", bus.busy); end
  endtask

  task automatic pulse_start(input logic empty);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.start_empty = empty;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.start_empty = 1'b0;
  endtask

  task automatic send_bytes(input byte_q_t b, input int prob, input bit mid_start);
    int i = 0;
    int c = 0;
    bit acc;
    while (i < b.size() && c < 20000) begin
      bus.in_valid = ($urandom_range(0, 99) < prob);
      bus.in_data  = b[i];
      bus.in_last  = (i == b.size() - 1);
      if (mid_start) begin
        bus.start = 1'($urandom_range(0, 1)); bus.start_empty = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      c++;
    end
    idle_inputs();
    total++;
    if (i != b.size()) begin bad++; $display("FAIL send_timeout sent=%0d want=%0d", i, b.size()); end
  endtask

  task automatic wait_hash(output logic [63:0] h);
    int c = 0;
    while (bus.hash_valid !== 1'b1 && c < 20000) begin @(negedge clk); c++; end
    total++;
    if (bus.hash_valid !== 1'b1) begin bad++; $display("FAIL hash_timeout hash_valid=%b want=1", bus.hash_valid); end
    h = bus.hash;
  endtask

  task automatic run_msg(input byte_q_t b, input int prob, input bit mid_start,
                         input string name, output logic [63:0] h);
    word_q_t exp_w;
    int err0;
    wait_idle();
    mi_log.delete();
    err0 = pulse_err;
    pulse_start(b.size() == 0);
    send_bytes(b, prob, mid_start);
    wait_hash(h);
    ref_words(b, exp_w);
    total++;
    if (h !== ref_hash(exp_w)) begin
      bad++; $display("FAIL %s_hash got=%h want=%h", name, h, ref_hash(exp_w));
    end
    total++;
    if (mi_log.size() != exp_w.size()) begin
      bad++; $display("FAIL %s_word_count got=%0d want=%0d", name, mi_log.size(), exp_w.size());
    end else begin
      foreach (exp_w[k]) begin
        total++;
        if (mi_log[k] !== exp_w[k]) begin
          bad++; $display("FAIL %s_core_mi[%0d] got=%h want=%h", name, k, mi_log[k], exp_w[k]);
        end
      end
    end
    total++;
    if (pulse_err != err0) begin
      bad++; $display("FAIL %s_pulse_rules violations=%0d want=0", name, pulse_err - err0);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL %s_done_idle busy=%b in_ready=%b want=0,0", name, bus.busy, bus.in_ready);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if ({bus.busy, bus.in_ready, bus.core_initalize, bus.core_compress, bus.core_finalize,
         bus.hash_valid} !== 6'b0 || bus.core_mi !== 64'h0 || bus.hash !== 64'h0) begin
      bad++;
      $display("FAIL %s busy=%b in_ready=%b pulses=%b%b%b hash_valid=%b core_mi=%h hash=%h want=all zero",
               name, bus.busy, bus.in_ready, bus.core_initalize, bus.core_compress,
               bus.core_finalize, bus.hash_valid, bus.core_mi, bus.hash);
    end
  endtask

  function automatic byte_q_t ramp(input int n);
    byte_q_t b;
    for (int i = 0; i < n; i++) b.push_back(8'(i));
    return b;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_hold");
    @(posedge clk); #3 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_release");
  endtask

  task automatic test_empty();
    logic [63:0] h;
    byte_q_t b;
    run_msg(b, 100, 1'b0, "empty", h);
    total++;
    if (h !== 64'h726fdb47dd0e0e31) begin bad++; $display("FAIL empty_vector got=%h want=726fdb47dd0e0e31", h); end
  endtask

  task automatic test_seven();
    logic [63:0] h;
    run_msg(ramp(7), 100, 1'b0, "seven", h);
    total++;
    if (mi_log.size() != 1 || mi_log[0] !== 64'h0706050403020100) begin
      bad++; $display("FAIL seven_word got_count=%0d want=1 word=0706050403020100", mi_log.size());
    end
  endtask

  task automatic test_eight();
    logic [63:0] h;
    run_msg(ramp(8), 100, 1'b0, "eight", h);
    total++;
    if (h !== 64'h93f5f5799a932462) begin bad++; $display("FAIL eight_vector got=%h want=93f5f5799a932462", h); end
    total++;
    if (mi_log.size() != 2 || mi_log[0] !== 64'h0706050403020100 || mi_log[1] !== 64'h0800000000000000) begin
      bad++; $display("FAIL eight_words got_count=%0d want=2 (0706050403020100, 0800000000000000)", mi_log.size());
    end
  endtask

  task automatic test_stall();
    logic [63:0] h;
    extra = 5;
    run_msg(ramp(8), 45, 1'b0, "stall", h);
    extra = 0;
    total++;
    if (h !== 64'h93f5f5799a932462) begin bad++; $display("FAIL stall_vector got=%h want=93f5f5799a932462", h); end
  endtask

  task automatic test_long();
    logic [63:0] h;
    byte_q_t b;
    for (int i = 0; i < 300; i++) b.push_back(8'($urandom));
    run_msg(b, 70, 1'b1, "long", h);
    total++;
    if (mi_log.size() == 0 || mi_log[mi_log.size()-1][63:56] !== 8'h2c) begin
      bad++; $display("FAIL long_len_byte count=%0d want last word top byte 2c", mi_log.size());
    end
  endtask

  task automatic test_random();
    logic [63:0] h;
    for (int t = 0; t < 8; t++) begin
      byte_q_t b;
      int n;
      n = $urandom_range(0, 24);
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      extra = $urandom_range(0, 3);
      run_msg(b, $urandom_range(30, 100), 1'b0, $sformatf("rand%0d_len%0d", t, n), h);
    end
    extra = 0;
  endtask

  task automatic test_reset_cwait();
    logic [63:0] h;
    int c = 0;
    extra = 3;
    wait_idle();
    pulse_start(1'b0);
    send_bytes(ramp(8), 100, 1'b0);
    while (bus.core_compress !== 1'b1 && c < 200) begin @(negedge clk); c++; end
    total++;
    if (bus.core_compress !== 1'b1) begin bad++; $display("FAIL cwait_reach compress=%b want=1", bus.core_compress); end
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("cwait_reset_async");
    @(negedge clk);
    check_reset_outputs("cwait_reset_cycle");
    @(posedge clk); #3 reset_n = 1'b1;
    extra = 0;
    run_msg(ramp(0), 100, 1'b0, "after_reset", h);
    total++;
    if (h !== 64'h726fdb47dd0e0e31) begin bad++; $display("FAIL after_reset_vector got=%h want=726fdb47dd0e0e31", h); end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_seven();
    test_eight();
    test_stall();
    test_long();
    test_random();
    test_reset_cwait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/siphash_msg_feeder.md
SIPHASH_MSG_FEEDER -- requirements
Module: siphash_msg_feeder

Interface
No parameters.
REQ-001 SHALL have port clk  in  1  clock; all flops rising-edge.
REQ-002 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port start  in  1  begin new message; sampled only in IDLE.
REQ-004 SHALL have port start_empty  in  1  with start: message has zero bytes.
REQ-005 SHALL have ports in_valid/in_ready  in/out  1  byte-stream handshake.
REQ-006 SHALL have port in_data  in  8  message byte.
REQ-007 SHALL have port in_last  in  1  marks final byte.
REQ-008 SHALL have ports core_initalize, core_compress, core_finalize  out  1  single-cycle command pulses to the SipHash core.
REQ-009 SHALL have port core_mi  out  64  message word to core.
REQ-010 SHALL have ports core_ready, core_word_valid  in  1  core status.
REQ-011 SHALL have port core_word  in  64  core hash result.
REQ-012 SHALL have ports hash  out  64, hash_valid  out  1, busy  out  1.
Key and round counts c/d are driven to the core externally; this block does not touch them.

Function
REQ-013 SHALL implement FSM states IDLE, INIT, COLLECT, COMP, CWAIT, FINAL, FWAIT; busy=1 in every state except IDLE.
REQ-014 IDLE: on start -> INIT; clear hash_valid, len_reg (8 bit), byte_cnt (3 bit), word_reg (64 bit), flags last_blk and len_pending.
REQ-015 INIT: wait core_ready=1, then assert core_initalize for exactly one cycle; next state COLLECT, or COMP with word_reg=0 and last_blk=1 if start_empty was captured at start.
REQ-016 COLLECT: in_ready=1; in_ready=0 in all other states.
REQ-017 On each accepted byte: word_reg[8*byte_cnt+7 : 8*byte_cnt] = in_data (little-endian lanes), byte_cnt+1 mod 8, len_reg+1 mod 256.
REQ-018 Accepted byte in lane 7 without in_last -> COMP.
REQ-019 Accepted byte with in_last in lane 0..6: word_reg[63:56] = updated len_reg, unused lanes zero, last_blk=1 -> COMP.
REQ-020 Accepted byte with in_last in lane 7: len_pending=1 -> COMP.
REQ-021 core_mi SHALL equal word_reg at all times.
REQ-022 COMP: wait core_ready=1, assert core_compress exactly one cycle -> CWAIT.
REQ-023 CWAIT: first cycle ignores core_ready (core lowers ready one cycle after compress); thereafter on core_ready=1: if last_blk -> FINAL; else if len_pending -> word_reg={len_reg,56'h0}, len_pending=0, last_blk=1 -> COMP; else word_reg=0 -> COLLECT.
REQ-024 FINAL: assert core_finalize exactly one cycle -> FWAIT.
REQ-025 FWAIT: on core_word_valid=1 and core_ready=1 (from second FWAIT cycle), hash=core_word, hash_valid=1 -> IDLE.
REQ-026 hash/hash_valid SHALL hold until next accepted start.
REQ-027 At most one of core_initalize/core_compress/core_finalize SHALL be high in any cycle; all are register outputs.
REQ-028 Messages of 256+ bytes: length byte is total length mod 256 (len_reg wraps).
REQ-029 start while busy=1 SHALL be ignored; in_valid outside COLLECT SHALL be ignored (no byte consumed).

Reset
REQ-030 reset_n low SHALL immediately force IDLE, busy=0, in_ready=0, all core_* pulses 0, core_mi=0, hash=0, hash_valid=0, counters/flags 0, including mid-message.

Verification
REQ-031 Key 0x0f0e..0100 to core, c=2 d=4, start+start_empty -> one compress with core_mi=0, then finalize; hash=0x726fdb47dd0e0e31.
REQ-032 Bytes 00..06 with in_last on 06 -> single compress with core_mi=0x0706050403020100, then finalize.
REQ-033 Bytes 00..07 with in_last on 07 -> compresses with core_mi 0x0706050403020100 then 0x0800000000000000; hash=0x93f5f5799a932462.
REQ-034 in_valid toggled randomly, core_ready held low 5 extra cycles after compress -> no byte lost, no pulse issued while core_ready=0, same hash as REQ-033.
REQ-035 300-byte message -> final length byte 0x2c; start asserted mid-message ignored.
REQ-036 reset_n pulsed low while in CWAIT -> all outputs at reset values next cycle; fresh start then yields REQ-031 result.
